// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: D-stage issue and source operands in, stall and
// forwarding selects out. The optional multiply/divide busy signals exist
// only when MDU_BUSY_EN is defined.
//
// Signalling: every signal is a level qualified by the clock edge. There is
// no valid/ready handshake on this bus. issue_valid marks a register writer
// in D. The outputs are combinational from the current slots and the D-side
// inputs.
interface hazard_scoreboard_if #(
   parameter int AW = 5,
   parameter int TW = 2,
   parameter int SW = 2
) ();
   logic          flush;
   logic          issue_valid;
   logic [AW-1:0] issue_addr;
   logic [TW-1:0] issue_tnew;
   logic [AW-1:0] rs_addr;
   logic [TW-1:0] rs_tuse;
   logic [AW-1:0] rt_addr;
   logic [TW-1:0] rt_tuse;
   logic          stall;
   logic [SW-1:0] fwd_rs_sel;
   logic [SW-1:0] fwd_rt_sel;
`ifdef MDU_BUSY_EN
   logic          md_req;
   logic          md_start;
   logic          md_is_div;
   logic          md_busy;
`endif

   // Pipeline side: drives the D-stage information and receives the decisions.
   modport master (
      output flush, issue_valid, issue_addr, issue_tnew,
      output rs_addr, rs_tuse, rt_addr, rt_tuse,
`ifdef MDU_BUSY_EN
      output md_req, md_start, md_is_div,
      input  md_busy,
`endif
      input  stall, fwd_rs_sel, fwd_rt_sel
   );

   // Scoreboard side.
   modport slave (
      input  flush, issue_valid, issue_addr, issue_tnew,
      input  rs_addr, rs_tuse, rt_addr, rt_tuse,
`ifdef MDU_BUSY_EN
      input  md_req, md_start, md_is_div,
      output md_busy,
`endif
      output stall, fwd_rs_sel, fwd_rt_sel
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers in slots 1..STAGES
// (E..W). Each slot counts its Tnew down once per cycle. From the slots the
// block resolves the D-stage stall and the rs/rt forwarding sources.
// Optional feature macro: MDU_BUSY_EN adds a multiply/divide busy counter
// that can also stall D.
// SW must satisfy 2**SW > STAGES so that every slot number fits in a select.
module hazard_scoreboard #(
   parameter int STAGES   = 3,
   parameter int AW       = 5,
   parameter int TW       = 2,
   parameter int SW       = 2
`ifdef MDU_BUSY_EN
   ,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
`endif
) (
   input logic             clk,
   input logic             reset,
   hazard_scoreboard_if.slave hs
);

   // Slot k of the pipeline lives at index k-1.
   logic [STAGES-1:0] valid_q, valid_d;
   logic [AW-1:0]     addr_q [STAGES];
   logic [AW-1:0]     addr_d [STAGES];
   logic [TW-1:0]     tnew_q [STAGES];
   logic [TW-1:0]     tnew_d [STAGES];

   logic              reg_stall;
   logic              md_stall;
   logic              stall_w;
   logic              issue_take;

   logic              rs_hit, rt_hit;
   logic [SW-1:0]     rs_slot, rt_slot;
   logic [TW-1:0]     rs_tnew, rt_tnew;

   // Youngest matching writer for each source. The scan runs oldest to
   // youngest so that a younger match overrides an older one.
   always_comb begin
      rs_hit  = 1'b0;
      rs_slot = '0;
      rs_tnew = '0;
      rt_hit  = 1'b0;
      rt_slot = '0;
      rt_tnew = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (valid_q[k] && (addr_q[k] == hs.rs_addr)) begin
            rs_hit  = 1'b1;
            rs_slot = SW'(k + 1);
            rs_tnew = tnew_q[k];
         end
         if (valid_q[k] && (addr_q[k] == hs.rt_addr)) begin
            rt_hit  = 1'b1;
            rt_slot = SW'(k + 1);
            rt_tnew = tnew_q[k];
         end
      end
      // Register 0 is never a real dependency.
      if (hs.rs_addr == '0) rs_hit = 1'b0;
      if (hs.rt_addr == '0) rt_hit = 1'b0;
   end

   // Stall when a source's youngest writer will not be ready by its Tuse.
   // Forward only from a writer whose result already exists (Tnew 0).
   always_comb begin
      reg_stall = (rs_hit && (rs_tnew > hs.rs_tuse)) ||
                  (rt_hit && (rt_tnew > hs.rt_tuse));
      stall_w   = reg_stall || md_stall;
   end

   assign hs.stall      = stall_w;
   assign hs.fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_slot : '0;
   assign hs.fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_slot : '0;

   // A stalled D has to leave slot 1 empty, otherwise the instruction would
   // enter the pipeline twice.
   assign issue_take = hs.issue_valid && (hs.issue_addr != '0) && !stall_w;

   // Slot advance. Slots shift every cycle whether or not D stalls, and Tnew
   // saturates at zero. A flush clears everything, including the new issue.
   always_comb begin
      valid_d[0] = issue_take;
      addr_d[0]  = issue_take ? hs.issue_addr : '0;
      tnew_d[0]  = issue_take ? hs.issue_tnew : '0;
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = valid_q[k-1];
         addr_d[k]  = addr_q[k-1];
         tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : (tnew_q[k-1] - TW'(1));
      end
      if (hs.flush) begin
         valid_d = '0;
         for (int k = 0; k < STAGES; k++) begin
            addr_d[k] = '0;
            tnew_d[k] = '0;
         end
      end
   end

   // Slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            addr_q[k] <= '0;
            tnew_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < STAGES; k++) begin
            addr_q[k] <= addr_d[k];
            tnew_q[k] <= tnew_d[k];
         end
      end
   end

`ifdef MDU_BUSY_EN
   localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int CW     = $clog2(MD_MAX + 1);

   logic [CW-1:0] md_cnt_q, md_cnt_d;
   logic          md_busy_w;

   assign md_busy_w  = (md_cnt_q != '0);
   assign hs.md_busy = md_busy_w;

   // An instruction that needs HI/LO or the MDU waits while the unit is busy
   // and also in the cycle that an operation starts.
   always_comb begin
      md_stall = hs.md_req && (md_busy_w || hs.md_start);
   end

   // Busy counter. A start is accepted only while idle, so a second start
   // cannot stretch an operation that is already running.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_busy_w) begin
         md_cnt_d = md_cnt_q - CW'(1);
      end else if (hs.md_start) begin
         md_cnt_d = hs.md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end
      if (hs.flush) begin
         md_cnt_d = '0;
      end
   end

   // Busy counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end
`else
   // Without the MDU, only register hazards stall D.
   always_comb begin
      md_stall = 1'b0;
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenario tasks followed by a
// randomized run checked against a writer-age reference model. The
// MDU_BUSY_EN scenario is built only when that macro is defined.
module tb_hazard_scoreboard;
   localparam int STAGES = 3;
   localparam int AW     = 5;
   localparam int TW     = 2;
   localparam int SW     = 2;
   localparam int OW     = 2 * SW + 1;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   hazard_scoreboard_if #(.AW(AW), .TW(TW), .SW(SW)) hs ();

   hazard_scoreboard #(.STAGES(STAGES), .AW(AW), .TW(TW), .SW(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .hs    (hs)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each slot records the writer and the Tnew it had on
   // issue. The current Tnew is derived from the writer's age.
   typedef struct {
      bit            v;
      logic [AW-1:0] a;
      int            t0;
   } wr_t;
   wr_t mdl [STAGES];

   logic [OW-1:0] exp_q [$];

   function automatic int mdl_tnew(input int k);
      return (mdl[k].t0 > k) ? (mdl[k].t0 - k) : 0;
   endfunction

   task automatic mdl_src(input logic [AW-1:0] a, input logic [TW-1:0] tuse,
                          output logic st, output logic [SW-1:0] sel);
      st  = 1'b0;
      sel = '0;
      if (a != 0) begin
         for (int k = 0; k < STAGES; k++) begin
            if (mdl[k].v && mdl[k].a == a) begin
               st  = (mdl_tnew(k) > int'(tuse));
               sel = (mdl_tnew(k) == 0) ? SW'(k + 1) : '0;
               break;
            end
         end
      end
   endtask

   task automatic mdl_eval(output logic [OW-1:0] e);
      logic st_s, st_t;
      logic [SW-1:0] s_s, s_t;
      mdl_src(hs.rs_addr, hs.rs_tuse, st_s, s_s);
      mdl_src(hs.rt_addr, hs.rt_tuse, st_t, s_t);
      e = {st_s | st_t, s_s, s_t};
   endtask

   task automatic mdl_clock(input logic st);
      if (reset || hs.flush) begin
         for (int k = 0; k < STAGES; k++) mdl[k].v = 1'b0;
      end else begin
         for (int k = STAGES - 1; k > 0; k--) mdl[k] = mdl[k-1];
         mdl[0].v  = hs.issue_valid && (hs.issue_addr != 0) && !st;
         mdl[0].a  = hs.issue_addr;
         mdl[0].t0 = int'(hs.issue_tnew);
      end
   endtask

   // Driver tasks
   task automatic set_d(input logic iv, input logic [AW-1:0] ia, input logic [TW-1:0] it,
                        input logic [AW-1:0] ra, input logic [TW-1:0] ru,
                        input logic [AW-1:0] ta, input logic [TW-1:0] tu);
      hs.issue_valid = iv;
      hs.issue_addr  = ia;
      hs.issue_tnew  = it;
      hs.rs_addr     = ra;
      hs.rs_tuse     = ru;
      hs.rt_addr     = ta;
      hs.rt_tuse     = tu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set_d(0, 0, 0, 0, 0, 0, 0);
      hs.flush = 1'b0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== '0) begin
            bad++;
            $display("FAIL reset_idle[%0d]: stall/rs/rt=%b expected 0", i,
                     {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
         end
         tick();
      end
   endtask

   task automatic test_forward_alu();
      set_d(1, 8, 1, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 8, 0, 0, 0);
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL alu_stall: stall=%b rs_sel=%0d expected 1/0", hs.stall, hs.fwd_rs_sel);
      end
      tick();
      total++;
      if ({hs.stall, hs.fwd_rs_sel} !== {1'b0, 2'd2}) begin
         bad++;
         $display("FAIL alu_fwd: stall=%b rs_sel=%0d expected 0/2", hs.stall, hs.fwd_rs_sel);
      end
      idle(3);
   endtask

   task automatic test_load_use();
      logic [SW:0] want [4];
      want[0] = {1'b1, 2'd0};
      want[1] = {1'b0, 2'd0};
      want[2] = {1'b0, 2'd3};
      want[3] = {1'b0, 2'd0};
      set_d(1, 9, 2, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 9, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({hs.stall, hs.fwd_rs_sel} !== want[i]) begin
            bad++;
            $display("FAIL load_use[%0d]: stall/rs_sel=%b expected %b", i,
                     {hs.stall, hs.fwd_rs_sel}, want[i]);
         end
         tick();
      end
      idle(3);
   endtask

   task automatic test_youngest();
      set_d(1, 5, 0, 0, 0, 0, 0);
      tick();
      set_d(1, 5, 0, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 0, 0, 5, 0);
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== {1'b0, 2'd0, 2'd1}) begin
         bad++;
         $display("FAIL youngest: stall/rs/rt=%b expected 0_00_01",
                  {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
      end
      set_d(1, 0, 0, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== '0) begin
         bad++;
         $display("FAIL addr_zero: stall/rs/rt=%b expected 0",
                  {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
      end
      idle(3);
   endtask

   task automatic test_stall_bubble();
      set_d(1, 7, 2, 0, 0, 0, 0);
      tick();
      set_d(1, 6, 0, 7, 0, 0, 0);
      #1;
      total++;
      if (hs.stall !== 1'b1) begin
         bad++;
         $display("FAIL bubble_stall: stall=%b expected 1", hs.stall);
      end
      tick();
      // Had addr 6 been taken it would sit in slot 1 with Tnew 0.
      set_d(0, 0, 0, 6, 0, 7, 0);
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== {1'b1, 2'd0, 2'd0}) begin
         bad++;
         $display("FAIL bubble_slot1: stall/rs/rt=%b expected 1_00_00",
                  {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
      end
      idle(3);
   endtask

   task automatic test_flush();
      set_d(1, 1, 3, 0, 0, 0, 0);
      tick();
      set_d(1, 2, 3, 0, 0, 0, 0);
      tick();
      set_d(1, 3, 3, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 1, 3, 3, 3);
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== '0) begin
         bad++;
         $display("FAIL flush_pre: stall/rs/rt=%b expected 0",
                  {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
      end
      set_d(0, 0, 0, 3, 0, 0, 0);
      #1;
      total++;
      if (hs.stall !== 1'b1) begin
         bad++;
         $display("FAIL flush_pre_stall: stall=%b expected 1", hs.stall);
      end
      set_d(1, 4, 0, 0, 0, 0, 0);
      hs.flush = 1'b1;
      tick();
      hs.flush = 1'b0;
      set_d(0, 0, 0, 4, 0, 2, 0);
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== '0) begin
         bad++;
         $display("FAIL flush_post: stall/rs/rt=%b expected 0",
                  {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
      end
      idle(3);
   endtask

   task automatic test_reset_mid_stall();
      set_d(1, 10, 3, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 10, 0, 0, 0);
      #1;
      total++;
      if (hs.stall !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_pre: stall=%b expected 1", hs.stall);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      total++;
      if ({hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel} !== '0) begin
         bad++;
         $display("FAIL rst_mid_post: stall/rs/rt=%b expected 0",
                  {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel});
      end
      idle(3);
   endtask

`ifdef MDU_BUSY_EN
   task automatic test_mdu();
      hs.md_start  = 1'b1;
      hs.md_is_div = 1'b1;
      tick();
      hs.md_start = 1'b0;
      hs.md_req   = 1'b1;
      for (int i = 0; i < 11; i++) begin
         #1;
         total++;
         if ({hs.md_busy, hs.stall} !== ((i < 10) ? 2'b11 : 2'b00)) begin
            bad++;
            $display("FAIL mdu_div[%0d]: busy/stall=%b expected %b", i,
                     {hs.md_busy, hs.stall}, (i < 10) ? 2'b11 : 2'b00);
         end
         tick();
      end
      hs.md_req    = 1'b0;
      hs.md_start  = 1'b1;
      hs.md_is_div = 1'b0;
      tick();
      hs.md_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         // A divide start during the multiply must be ignored.
         hs.md_start  = (i == 1);
         hs.md_is_div = 1'b1;
         #1;
         total++;
         if (hs.md_busy !== (i < 5)) begin
            bad++;
            $display("FAIL mdu_mult[%0d]: busy=%b expected %b", i, hs.md_busy, (i < 5));
         end
         tick();
         hs.md_start = 1'b0;
      end
      hs.md_start = 1'b1;
      hs.md_req   = 1'b1;
      #1;
      total++;
      if (hs.stall !== 1'b1) begin
         bad++;
         $display("FAIL mdu_start_req: stall=%b expected 1", hs.stall);
      end
      hs.flush = 1'b1;
      tick();
      hs.flush    = 1'b0;
      hs.md_start = 1'b0;
      hs.md_req   = 1'b0;
      #1;
      total++;
      if (hs.md_busy !== 1'b0) begin
         bad++;
         $display("FAIL mdu_flush: busy=%b expected 0", hs.md_busy);
      end
      idle(2);
   endtask
`endif

   task automatic test_random();
      logic [OW-1:0] e, got;
      reset = 1'b1;
      idle(1);
      mdl_clock(1'b0);
      reset = 1'b0;
      for (int i = 0; i < 600; i++) begin
         set_d(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), TW'($urandom_range(0, 3)),
               AW'($urandom_range(0, 7)), TW'($urandom_range(0, 3)),
               AW'($urandom_range(0, 7)), TW'($urandom_range(0, 3)));
         hs.flush = ($urandom_range(0, 19) == 0);
         #1;
         mdl_eval(e);
         exp_q.push_back(e);
         got = {hs.stall, hs.fwd_rs_sel, hs.fwd_rt_sel};
         e = exp_q.pop_front();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL random[%0d]: stall/rs/rt=%b expected %b", i, got, e);
         end
         @(posedge clk);
         mdl_clock(e[OW-1]);
         #1;
      end
      idle(3);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      hs.flush = 1'b0;
      set_d(0, 0, 0, 0, 0, 0, 0);
`ifdef MDU_BUSY_EN
      hs.md_req    = 1'b0;
      hs.md_start  = 1'b0;
      hs.md_is_div = 1'b0;
`endif
      for (int k = 0; k < STAGES; k++) begin
         mdl[k].v  = 1'b0;
         mdl[k].a  = '0;
         mdl[k].t0 = 0;
      end
      tick();
      test_reset();
      test_forward_alu();
      test_load_use();
      test_youngest();
      test_stall_bubble();
      test_flush();
      test_reset_mid_stall();
`ifdef MDU_BUSY_EN
      test_mdu();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
